// File: rtl/wave_bank_swap_ctrl.sv
// Double-buffer bank controller for one wavetable channel.
// Loads go to a spare bank; the play bank swaps at a cycle boundary.
module wave_bank_swap_ctrl #(
  parameter int ADDRWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_req,
  input  logic [1:0]           tgt_bank,
  input  logic                 we_in,
  input  logic [ADDRWIDTH-1:0] waddr_in,
  input  logic                 load_done,
  input  logic [ADDRWIDTH-1:0] raddr,
  input  logic                 rd_en,
  output logic                 we_out,
  output logic [1:0]           wbank,
  output logic [1:0]           rbank,
  output logic                 busy,
  output logic                 swap_pulse,
  output logic                 err,
  output logic [ADDRWIDTH:0]   word_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    ARMED   = 2'd2
  } state_t;

  localparam logic [ADDRWIDTH:0] FULL =
    {1'b1, {ADDRWIDTH{1'b0}}};
  localparam logic [ADDRWIDTH-1:0] LAST =
    {ADDRWIDTH{1'b1}};

  state_t                 state;
  state_t                 state_n;
  logic [1:0]             rbank_n;
  logic [1:0]             wbank_n;
  logic [ADDRWIDTH:0]     cnt_n;
  logic [ADDRWIDTH:0]     cnt_inc;
  logic [ADDRWIDTH-1:0]   prev_raddr;
  logic                   err_n;
  logic                   swap_n;
  logic                   wrap;

  // The address is routed straight to the arbiter by the caller.
  logic unused_waddr;
  assign unused_waddr = ^waddr_in;

  assign busy    = (state != IDLE);
  assign wrap    = rd_en && (prev_raddr == LAST) && (raddr == '0);
  assign cnt_inc = (word_cnt == FULL) ? word_cnt : word_cnt + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Bank, counter, previous read address and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rbank      <= 2'd0;
      wbank      <= 2'd1;
      word_cnt   <= '0;
      prev_raddr <= '0;
      err        <= 1'b0;
      swap_pulse <= 1'b0;
    end else begin
      rbank      <= rbank_n;
      wbank      <= wbank_n;
      word_cnt   <= cnt_n;
      prev_raddr <= raddr;
      err        <= err_n;
      swap_pulse <= swap_n;
    end
  end

  // Next-state, write gating and error detection.
  always_comb begin
    state_n = state;
    rbank_n = rbank;
    wbank_n = wbank;
    cnt_n   = word_cnt;
    err_n   = 1'b0;
    swap_n  = 1'b0;
    we_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (we_in) err_n = 1'b1;
        if (load_req) begin
          if (tgt_bank != rbank) begin
            wbank_n = tgt_bank;
            cnt_n   = '0;
            state_n = LOADING;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOADING: begin
        we_out = we_in;
        if (we_in)    cnt_n = cnt_inc;
        if (load_req) err_n = 1'b1;
        if (load_done) begin
          if (cnt_n == FULL) begin
            state_n = ARMED;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end
      ARMED: begin
        if (we_in || load_req) err_n = 1'b1;
        if (!rd_en || wrap) begin
          rbank_n = wbank;
          swap_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wave_bank_swap_ctrl.sv
// Scoreboard bench for wave_bank_swap_ctrl.
// Expectations are queued with stimulus and drained on DUT output.
module tb_wave_bank_swap_ctrl;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_req;
  logic [1:0]    tgt_bank;
  logic          we_in;
  logic [AW-1:0] waddr_in;
  logic          load_done;
  logic [AW-1:0] raddr;
  logic          rd_en;
  logic          we_out;
  logic [1:0]    wbank;
  logic [1:0]    rbank;
  logic          busy;
  logic          swap_pulse;
  logic          err;
  logic [AW:0]   word_cnt;

  wave_bank_swap_ctrl #(.ADDRWIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .tgt_bank   (tgt_bank),
    .we_in      (we_in),
    .waddr_in   (waddr_in),
    .load_done  (load_done),
    .raddr      (raddr),
    .rd_en      (rd_en),
    .we_out     (we_out),
    .wbank      (wbank),
    .rbank      (rbank),
    .busy       (busy),
    .swap_pulse (swap_pulse),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {
    S_RBANK, S_WBANK, S_BUSY, S_ERR,
    S_SWAP, S_CNT, S_WE
  } sel_e;

  typedef struct {
    string tag;
    sel_e  sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic int obs(sel_e s);
    case (s)
      S_RBANK: return int'(rbank);
      S_WBANK: return int'(wbank);
      S_BUSY:  return int'(busy);
      S_ERR:   return int'(err);
      S_SWAP:  return int'(swap_pulse);
      S_CNT:   return int'(word_cnt);
      default: return int'(we_out);
    endcase
  endfunction

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(string tag, sel_e s, int v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_vals(string pfx);
    push({pfx, "_rbank"}, S_RBANK, 0);
    push({pfx, "_wbank"}, S_WBANK, 1);
    push({pfx, "_busy"},  S_BUSY,  0);
    push({pfx, "_err"},   S_ERR,   0);
    push({pfx, "_swap"},  S_SWAP,  0);
    push({pfx, "_cnt"},   S_CNT,   0);
  endtask

  // Mid-cycle asynchronous reset, checked before any edge.
  task automatic async_reset(string pfx);
    #3;
    rst = 1'b1;
    #1;
    reset_vals(pfx);
    drain();
    #2;
    rst = 1'b0;
  endtask

  task automatic writes(int n);
    for (int i = 0; i < n; i++) begin
      we_in    = 1'b1;
      waddr_in = AW'(i);
      cyc();
    end
    we_in = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    load_req  = 1'b0;
    tgt_bank  = 2'd0;
    we_in     = 1'b0;
    waddr_in  = '0;
    load_done = 1'b0;
    raddr     = '0;
    rd_en     = 1'b1;
    cyc();
    cyc();
    reset_vals("rst");
    push("rst_we", S_WE, 0);
    drain();
    rst = 1'b0;
    cyc();

    // Illegal target: same bank as rbank.
    load_req = 1'b1;
    tgt_bank = 2'd0;
    cyc();
    load_req = 1'b0;
    push("ill_err", S_ERR, 1);
    push("ill_busy", S_BUSY, 0);
    push("ill_wbank", S_WBANK, 1);
    drain();
    cyc();
    push("ill_err_clr", S_ERR, 0);
    drain();

    // Write strobe while idle.
    we_in = 1'b1;
    #1;
    push("idle_we", S_WE, 0);
    drain();
    cyc();
    we_in = 1'b0;
    push("idle_we_err", S_ERR, 1);
    drain();

    // Full load into bank 2 with the reader running.
    raddr    = 8'd10;
    load_req = 1'b1;
    tgt_bank = 2'd2;
    cyc();
    load_req = 1'b0;
    push("ld_busy", S_BUSY, 1);
    push("ld_wbank", S_WBANK, 2);
    push("ld_cnt0", S_CNT, 0);
    drain();
    for (int i = 0; i < 256; i++) begin
      we_in    = 1'b1;
      waddr_in = AW'(i);
      load_req = (i == 5);
      tgt_bank = 2'd3;
      if (i == 0) begin
        #1;
        push("ld_we_pass", S_WE, 1);
        drain();
      end
      cyc();
      if (i == 5) begin
        push("ld_req_err", S_ERR, 1);
        push("ld_req_wbank", S_WBANK, 2);
        drain();
      end
    end
    we_in    = 1'b0;
    load_req = 1'b0;
    push("ld_cnt256", S_CNT, 256);
    drain();
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
    push("arm_busy", S_BUSY, 1);
    push("arm_err", S_ERR, 0);
    push("arm_rbank", S_RBANK, 0);
    drain();
    for (int v = 250; v <= 255; v++) begin
      raddr = AW'(v);
      we_in = (v == 252);
      if (v == 252) begin
        #1;
        push("arm_we_gate", S_WE, 0);
        drain();
      end
      cyc();
      we_in = 1'b0;
      push("arm_hold_rbank", S_RBANK, 0);
      push("arm_hold_swap", S_SWAP, 0);
      push("arm_hold_busy", S_BUSY, 1);
      if (v == 252) push("arm_we_err", S_ERR, 1);
      drain();
    end
    raddr = 8'd0;
    cyc();
    push("wrap_rbank", S_RBANK, 2);
    push("wrap_swap", S_SWAP, 1);
    push("wrap_busy", S_BUSY, 0);
    push("wrap_wbank", S_WBANK, 2);
    drain();
    raddr = 8'd1;
    cyc();
    push("wrap_swap_end", S_SWAP, 0);
    push("wrap_rbank_hold", S_RBANK, 2);
    drain();

    // Asynchronous reset with rbank already moved.
    async_reset("arst");
    cyc();

    // Short load is aborted.
    load_req = 1'b1;
    tgt_bank = 2'd1;
    cyc();
    load_req = 1'b0;
    writes(100);
    load_done = 1'b1;
    cyc();
    load_done = 1'b0;
    push("abort_err", S_ERR, 1);
    push("abort_cnt", S_CNT, 100);
    push("abort_busy", S_BUSY, 0);
    push("abort_rbank", S_RBANK, 0);
    push("abort_swap", S_SWAP, 0);
    drain();
    cyc();
    push("abort_swap2", S_SWAP, 0);
    push("abort_err_clr", S_ERR, 0);
    drain();

    // Reader stopped; last write coincides with load_done.
    rd_en    = 1'b0;
    load_req = 1'b1;
    tgt_bank = 2'd3;
    cyc();
    load_req = 1'b0;
    writes(255);
    we_in     = 1'b1;
    load_done = 1'b1;
    cyc();
    we_in     = 1'b0;
    load_done = 1'b0;
    push("stop_arm_busy", S_BUSY, 1);
    push("stop_arm_cnt", S_CNT, 256);
    push("stop_arm_err", S_ERR, 0);
    push("stop_arm_rbank", S_RBANK, 0);
    drain();
    cyc();
    push("stop_rbank", S_RBANK, 3);
    push("stop_swap", S_SWAP, 1);
    push("stop_busy", S_BUSY, 0);
    drain();
    cyc();
    push("stop_swap_end", S_SWAP, 0);
    drain();

    // Reset in the middle of a load.
    rd_en    = 1'b1;
    load_req = 1'b1;
    tgt_bank = 2'd1;
    cyc();
    load_req = 1'b0;
    writes(128);
    push("mid_cnt", S_CNT, 128);
    push("mid_busy", S_BUSY, 1);
    drain();
    async_reset("mid");
    cyc();
    push("mid_after_busy", S_BUSY, 0);
    push("mid_after_err", S_ERR, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
